// File: rtl/bf_loop_unit.sv
// Loop-control unit for the brainfuck datapath: a loop-start address stack for
// one-cycle backward jumps plus a nested-bracket counter for forward skips.
module bf_loop_unit #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           op_valid,
   input  logic [1:0]                     op_code,
   input  logic                           cell_zero,
   input  logic [ADDR_W-1:0]              pc_in,
   input  logic                           err_clr,
   output logic                           op_ready,
   output logic                           jump,
   output logic [ADDR_W-1:0]              jump_target,
   output logic                           skipping,
   output logic [$clog2(DEPTH+1)-1:0]     depth,
   output logic                           err_overflow,
   output logic                           err_underflow
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_SKIP = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam logic [1:0] OP_OPEN  = 2'd0;
   localparam logic [1:0] OP_CLOSE = 2'd1;

   logic [1:0]        state_p1;
   logic [CNT_W-1:0]  cnt_p1;
   logic [ADDR_W-1:0] stk [DEPTH];

   logic              vld_p0;
   logic              is_open_p0;
   logic              is_close_p0;
   logic              push_p0;
   logic              stk_full_p0;
   logic              stk_empty_p0;
   logic [IW-1:0]     top_idx_p0;
   logic [ADDR_W-1:0] top_p0;

   assign op_ready     = (state_p1 != ST_ERR);
   assign skipping     = (state_p1 == ST_SKIP);
   assign vld_p0       = op_valid & op_ready;
   assign is_open_p0   = (op_code == OP_OPEN);
   assign is_close_p0  = (op_code == OP_CLOSE);
   assign stk_full_p0  = (depth == DW'(DEPTH));
   assign stk_empty_p0 = (depth == '0);
   assign top_idx_p0   = IW'(depth - DW'(1));
   assign top_p0       = stk[top_idx_p0];
   assign push_p0      = vld_p0 & ~err_clr & (state_p1 == ST_RUN) & is_open_p0 &
                         ~cell_zero & ~stk_full_p0;

   // Stack storage is data only; depth alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (push_p0) begin
         stk[IW'(depth)] <= pc_in;
      end
   end

   // Accept edge: control state, depth and the registered jump request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_p1      <= ST_RUN;
         cnt_p1        <= '0;
         depth         <= '0;
         jump          <= 1'b0;
         jump_target   <= '0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         jump <= 1'b0;
         if (err_clr) begin
            state_p1      <= ST_RUN;
            cnt_p1        <= '0;
            depth         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
         end else if (vld_p0) begin
            case (state_p1)
               ST_RUN: begin
                  if (is_open_p0) begin
                     if (cell_zero) begin
                        state_p1 <= ST_SKIP;
                        cnt_p1   <= CNT_W'(1);
                     end else if (stk_full_p0) begin
                        err_overflow <= 1'b1;
                        state_p1     <= ST_ERR;
                     end else begin
                        depth <= depth + DW'(1);
                     end
                  end else if (is_close_p0) begin
                     if (stk_empty_p0) begin
                        err_underflow <= 1'b1;
                        state_p1      <= ST_ERR;
                     end else if (cell_zero) begin
                        depth <= depth - DW'(1);
                     end else begin
                        jump        <= 1'b1;
                        jump_target <= top_p0 + ADDR_W'(1);
                     end
                  end
               end
               ST_SKIP: begin
                  if (is_open_p0) begin
                     if (cnt_p1 == '1) begin
                        err_overflow <= 1'b1;
                        state_p1     <= ST_ERR;
                     end else begin
                        cnt_p1 <= cnt_p1 + CNT_W'(1);
                     end
                  end else if (is_close_p0) begin
                     cnt_p1 <= cnt_p1 - CNT_W'(1);
                     if (cnt_p1 == CNT_W'(1)) begin
                        state_p1 <= ST_RUN;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
